// File: rtl/main_memory_ctrl_if.sv
// Cache-side bundle for main_memory_ctrl: data request port, instruction request port and the
// shared status both caches poll before issuing a request.
interface main_memory_ctrl_if #(
    parameter int unsigned ADDR_WIDTH       = 17,
    parameter int unsigned LEN              = 32,
    parameter int unsigned ENTRY_INDEX_SIZE = 3
);
    logic [1:0]                d_mem_vis_signal;
    logic [ADDR_WIDTH-1:0]     d_mem_vis_addr;
    logic [LEN-1:0]            d_mem_writen_data;
    logic [ENTRY_INDEX_SIZE:0] d_write_length;
    logic [LEN-1:0]            d_mem_data;
    logic [1:0]                i_mem_vis_signal;
    logic [ADDR_WIDTH-1:0]     i_mem_vis_addr;
    logic [LEN-1:0]            i_mem_data;
    logic [1:0]                mem_status;

    modport master (
        output d_mem_vis_signal, d_mem_vis_addr, d_mem_writen_data, d_write_length,
        output i_mem_vis_signal, i_mem_vis_addr,
        input  d_mem_data, i_mem_data, mem_status
    );

    modport slave (
        input  d_mem_vis_signal, d_mem_vis_addr, d_mem_writen_data, d_write_length,
        input  i_mem_vis_signal, i_mem_vis_addr,
        output d_mem_data, i_mem_data, mem_status
    );
endinterface

// File: rtl/main_memory_ctrl.sv
// Byte-addressed main memory serving a data cache (read, burst read, write sequence) and an
// instruction cache; the data port wins arbitration. Words are little-endian, addresses wrap.
module main_memory_ctrl #(
    parameter int unsigned ADDR_WIDTH       = 17,
    parameter int unsigned LEN              = 32,
    parameter int unsigned BYTE_SIZE        = 8,
    parameter int unsigned VECTOR_SIZE      = 8,
    parameter int unsigned ENTRY_INDEX_SIZE = 3
) (
    input logic               clk,
    input logic               rst_n,
    main_memory_ctrl_if.slave bus
);
    localparam logic [1:0] MEM_NOP        = 2'b00;
    localparam logic [1:0] MEM_READ       = 2'b01;
    localparam logic [1:0] MEM_WRITE      = 2'b10;
    localparam logic [1:0] MEM_READ_BURST = 2'b11;

    localparam logic [1:0] MEM_RESTING      = 2'b00;
    localparam logic [1:0] MEM_INST_WORKING = 2'b01;
    localparam logic [1:0] MEM_DATA_WORKING = 2'b10;

    localparam int unsigned     BytesPerWord = LEN / BYTE_SIZE;
    localparam int unsigned     CntW         = ENTRY_INDEX_SIZE + 1;
    localparam logic [CntW-1:0] VecMax       = CntW'(VECTOR_SIZE);
    localparam logic [CntW-1:0] CntOne       = CntW'(1);

    typedef enum logic [1:0] {StResting, StInstWorking, StDataWorking} state_e;
    typedef enum logic [1:0] {OpRead, OpBurst, OpWrite} op_e;

    logic [BYTE_SIZE-1:0] mem_q [2**ADDR_WIDTH];

    state_e                state_q;
    op_e                   op_q;
    logic [1:0]            status_q;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       len_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN-1:0]        d_data_q;
    logic [LEN-1:0]        i_data_q;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [LEN-1:0]        wr_data;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign beat_addr      = base_q + (ADDR_WIDTH'(cnt_q) << 2);
    assign bus.mem_status = status_q;
    assign bus.d_mem_data = d_data_q;
    assign bus.i_mem_data = i_data_q;

    function automatic logic [LEN-1:0] read_word(input logic [ADDR_WIDTH-1:0] addr);
        logic [LEN-1:0] word;
        word = '0;
        for (int unsigned b = 0; b < BytesPerWord; b++) begin
            word[b*BYTE_SIZE +: BYTE_SIZE] = mem_q[addr + ADDR_WIDTH'(b)];
        end
        return word;
    endfunction

    function automatic logic [CntW-1:0] clamp_len(input logic [CntW-1:0] len);
        if (len == '0) return CntOne;
        if (len > VecMax) return VecMax;
        return len;
    endfunction

    // Gating on rst_n keeps a held reset from committing an accept-edge write.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = beat_addr;
        wr_data = bus.d_mem_writen_data;
        if (rst_n && bus.d_mem_vis_signal == MEM_WRITE) begin
            if (state_q == StResting) begin
                wr_en   = 1'b1;
                wr_addr = bus.d_mem_vis_addr;
            end else if (state_q == StDataWorking && op_q == OpWrite && cnt_q != len_q) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < BytesPerWord; b++) begin
                mem_q[wr_addr + ADDR_WIDTH'(b)] <= wr_data[b*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StResting;
            status_q <= MEM_RESTING;
            op_q     <= OpRead;
            cnt_q    <= '0;
            len_q    <= '0;
            base_q   <= '0;
            d_data_q <= '0;
            i_data_q <= '0;
        end else begin
            unique case (state_q)
                StResting: begin
                    if (bus.d_mem_vis_signal != MEM_NOP) begin
                        base_q   <= bus.d_mem_vis_addr;
                        cnt_q    <= CntOne;
                        state_q  <= StDataWorking;
                        status_q <= MEM_DATA_WORKING;
                        case (bus.d_mem_vis_signal)
                            MEM_READ: begin
                                op_q     <= OpRead;
                                d_data_q <= read_word(bus.d_mem_vis_addr);
                            end
                            MEM_READ_BURST: begin
                                op_q     <= OpBurst;
                                d_data_q <= read_word(bus.d_mem_vis_addr);
                            end
                            default: begin
                                op_q  <= OpWrite;
                                len_q <= clamp_len(bus.d_write_length);
                            end
                        endcase
                    end else if (bus.i_mem_vis_signal == MEM_READ) begin
                        i_data_q <= read_word(bus.i_mem_vis_addr);
                        state_q  <= StInstWorking;
                        status_q <= MEM_INST_WORKING;
                    end
                end
                StInstWorking: begin
                    state_q  <= StResting;
                    status_q <= MEM_RESTING;
                end
                StDataWorking: begin
                    // Any signal that does not continue the current sequence ends it and is dropped.
                    if (op_q == OpBurst && bus.d_mem_vis_signal == MEM_READ_BURST &&
                        cnt_q < VecMax) begin
                        d_data_q <= read_word(beat_addr);
                        cnt_q    <= cnt_q + CntOne;
                    end else if (op_q == OpWrite && bus.d_mem_vis_signal == MEM_WRITE &&
                                 cnt_q != len_q) begin
                        cnt_q <= cnt_q + CntOne;
                    end else begin
                        state_q  <= StResting;
                        status_q <= MEM_RESTING;
                    end
                end
                default: begin
                    state_q  <= StResting;
                    status_q <= MEM_RESTING;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Bench for main_memory_ctrl: directed vector table, then random transactions checked
// against a transaction-level byte-array model, then a mid-burst reset.
module tb_main_memory_ctrl;
    localparam int         AW     = 17;
    localparam int         MEMSZ  = 1 << AW;
    localparam logic [1:0] NOP    = 2'd0;
    localparam logic [1:0] RD     = 2'd1;
    localparam logic [1:0] WR     = 2'd2;
    localparam logic [1:0] BR     = 2'd3;
    localparam logic [1:0] S_REST = 2'd0;
    localparam logic [1:0] S_INST = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    typedef struct {
        logic [1:0]  ds;
        logic [16:0] da;
        logic [31:0] wd;
        logic [3:0]  wl;
        logic [1:0]  is;
        logic [16:0] ia;
        logic [1:0]  st;
        logic [31:0] d;
        logic [31:0] i;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0]  ref_mem [MEMSZ];
    logic [31:0] d_exp;
    logic [31:0] i_exp;
    vec_t        tbl [$];

    main_memory_ctrl_if #(.ADDR_WIDTH(AW), .LEN(32), .ENTRY_INDEX_SIZE(3)) bus ();

    main_memory_ctrl #(
        .ADDR_WIDTH(AW), .LEN(32), .BYTE_SIZE(8), .VECTOR_SIZE(8), .ENTRY_INDEX_SIZE(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int clamp_l(input int lenf);
        if (lenf == 0) return 1;
        if (lenf > 8) return 8;
        return lenf;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [16:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[a + 17'(b)];
        return w;
    endfunction

    task automatic ref_wr(input logic [16:0] a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) ref_mem[a + 17'(b)] = w[8*b +: 8];
    endtask

    function automatic logic [16:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 17'(32'h1FF00 + $urandom_range(0, 255));
        return 17'($urandom_range(0, 32'h7FF - 40));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bus(input string name, input logic [1:0] st);
        check({name, ".status"}, 32'(bus.mem_status), 32'(st));
        check({name, ".d_data"}, bus.d_mem_data, d_exp);
        check({name, ".i_data"}, bus.i_mem_data, i_exp);
    endtask

    task automatic drive(input logic [1:0] ds, input logic [16:0] da, input logic [31:0] wd,
                         input logic [3:0] wl, input logic [1:0] is, input logic [16:0] ia);
        bus.d_mem_vis_signal  = ds;
        bus.d_mem_vis_addr    = da;
        bus.d_mem_writen_data = wd;
        bus.d_write_length    = wl;
        bus.i_mem_vis_signal  = is;
        bus.i_mem_vis_addr    = ia;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [1:0] ds, input logic [16:0] da, input logic [31:0] wd,
                       input logic [3:0] wl, input logic [1:0] is, input logic [16:0] ia,
                       input logic [1:0] st, input logic [31:0] d, input logic [31:0] i);
        vec_t v;
        v.ds = ds; v.da = da; v.wd = wd; v.wl = wl; v.is = is; v.ia = ia;
        v.st = st; v.d = d; v.i = i;
        tbl.push_back(v);
    endtask

    // Drives `beats` WRITE cycles; only the first L = clamp(lenf) land in memory.
    task automatic write_seq(input logic [16:0] a, input int lenf, input int beats);
        int          l;
        logic [31:0] w;
        l = clamp_l(lenf);
        for (int e = 0; e < beats; e++) begin
            w = $urandom;
            drive(WR, a, w, 4'(lenf), NOP, 17'h0);
            tick();
            if (e < l) begin
                ref_wr(a + 17'(4 * e), w);
                check_bus("wseq", S_DATA);
            end else begin
                check_bus("wseq_end", S_REST);
            end
        end
        drive(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0);
        tick();
        check_bus("wseq_idle", S_REST);
    endtask

    task automatic burst_seq(input logic [16:0] a, input int hold);
        for (int e = 0; e < hold; e++) begin
            drive(BR, (e == 0) ? a : 17'($urandom), 32'h0, 4'd0, NOP, 17'h0);
            tick();
            if (e < 8) begin
                d_exp = ref_rd(a + 17'(4 * e));
                check_bus("burst", S_DATA);
            end else begin
                check_bus("burst_end", S_REST);
            end
        end
        drive(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0);
        tick();
        check_bus("burst_idle", S_REST);
    endtask

    task automatic read_one(input logic [16:0] a);
        drive(RD, a, 32'h0, 4'd0, NOP, 17'h0);
        tick();
        d_exp = ref_rd(a);
        check_bus("read", S_DATA);
        drive(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0);
        tick();
        check_bus("read_idle", S_REST);
    endtask

    task automatic inst_read(input logic [16:0] ia, input logic [16:0] da, input bit with_d);
        drive(with_d ? RD : NOP, da, 32'h0, 4'd0, RD, ia);
        tick();
        if (with_d) begin
            d_exp = ref_rd(da);
            check_bus("arb", S_DATA);
        end else begin
            i_exp = ref_rd(ia);
            check_bus("iread", S_INST);
        end
        drive(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0);
        tick();
        check_bus("iread_idle", S_REST);
    endtask

    initial begin
        logic [16:0] a;
        int          kind;
        int          lenf;

        rst_n = 1'b0;
        drive(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0);
        d_exp = 32'h0;
        i_exp = 32'h0;
        #12;
        check_bus("reset", S_REST);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: one row per clock edge.
        add(WR, 17'h104, 32'h0, 4'd1, NOP, 17'h0, S_DATA, 32'h0, 32'h0);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'h0, 32'h0);
        add(WR, 17'h100, 32'hDEADBEEF, 4'd1, NOP, 17'h0, S_DATA, 32'h0, 32'h0);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'h0, 32'h0);
        add(RD, 17'h100, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'hDEADBEEF, 32'h0);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'hDEADBEEF, 32'h0);
        add(RD, 17'h101, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'h00DEADBE, 32'h0);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'h00DEADBE, 32'h0);
        for (int k = 0; k < 8; k++)
            add(WR, 17'h200, 32'(k + 1), 4'd8, NOP, 17'h0, S_DATA, 32'h00DEADBE, 32'h0);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'h00DEADBE, 32'h0);
        for (int k = 0; k < 8; k++)
            add(BR, (k == 0) ? 17'h200 : 17'h7F0, 32'h0, 4'd0, NOP, 17'h0, S_DATA,
                32'(k + 1), 32'h0);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'd8, 32'h0);
        for (int k = 0; k < 3; k++)
            add(BR, 17'h200, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'(k + 1), 32'h0);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'd3, 32'h0);
        // Simultaneous requests: data wins, instruction must be re-issued.
        add(RD, 17'h100, 32'h0, 4'd0, RD, 17'h204, S_DATA, 32'hDEADBEEF, 32'h0);
        add(NOP, 17'h0, 32'h0, 4'd0, RD, 17'h204, S_REST, 32'hDEADBEEF, 32'h0);
        add(NOP, 17'h0, 32'h0, 4'd0, RD, 17'h204, S_INST, 32'hDEADBEEF, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'hDEADBEEF, 32'd2);
        // Address wrap at the top of memory.
        add(WR, 17'h1FFF8, 32'h11223344, 4'd2, NOP, 17'h0, S_DATA, 32'hDEADBEEF, 32'd2);
        add(WR, 17'h1FFF8, 32'h55667788, 4'd2, NOP, 17'h0, S_DATA, 32'hDEADBEEF, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'hDEADBEEF, 32'd2);
        add(WR, 17'h0, 32'h99AABBCC, 4'd3, NOP, 17'h0, S_DATA, 32'hDEADBEEF, 32'd2);
        add(WR, 17'h0, 32'hDDEEFF00, 4'd3, NOP, 17'h0, S_DATA, 32'hDEADBEEF, 32'd2);
        add(WR, 17'h0, 32'h12345678, 4'd3, NOP, 17'h0, S_DATA, 32'hDEADBEEF, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'hDEADBEEF, 32'd2);
        add(BR, 17'h1FFF8, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'h11223344, 32'd2);
        add(BR, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'h55667788, 32'd2);
        add(BR, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'h99AABBCC, 32'd2);
        add(BR, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'hDDEEFF00, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'hDDEEFF00, 32'd2);
        add(RD, 17'h1FFFE, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'hBBCC5566, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'hBBCC5566, 32'd2);
        // Length clamp: 0 behaves as 1, 9 behaves as 8.
        add(WR, 17'h304, 32'h5A5A5A5A, 4'd1, NOP, 17'h0, S_DATA, 32'hBBCC5566, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'hBBCC5566, 32'd2);
        add(WR, 17'h340, 32'h77777777, 4'd1, NOP, 17'h0, S_DATA, 32'hBBCC5566, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'hBBCC5566, 32'd2);
        add(WR, 17'h300, 32'hC0, 4'd0, NOP, 17'h0, S_DATA, 32'hBBCC5566, 32'd2);
        add(WR, 17'h300, 32'hC1, 4'd0, NOP, 17'h0, S_REST, 32'hBBCC5566, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'hBBCC5566, 32'd2);
        add(RD, 17'h300, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'hC0, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'hC0, 32'd2);
        add(RD, 17'h304, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'h5A5A5A5A, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'h5A5A5A5A, 32'd2);
        for (int k = 0; k < 8; k++)
            add(WR, 17'h320, 32'(32'h11 + k), 4'd9, NOP, 17'h0, S_DATA, 32'h5A5A5A5A, 32'd2);
        add(WR, 17'h320, 32'h19, 4'd9, NOP, 17'h0, S_REST, 32'h5A5A5A5A, 32'd2);
        add(WR, 17'h3A0, 32'h1A, 4'd1, NOP, 17'h0, S_DATA, 32'h5A5A5A5A, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'h5A5A5A5A, 32'd2);
        add(RD, 17'h33C, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'h18, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'h18, 32'd2);
        add(RD, 17'h340, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'h77777777, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'h77777777, 32'd2);
        add(RD, 17'h3A0, 32'h0, 4'd0, NOP, 17'h0, S_DATA, 32'h1A, 32'd2);
        add(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0, S_REST, 32'h1A, 32'd2);

        foreach (tbl[n]) begin
            drive(tbl[n].ds, tbl[n].da, tbl[n].wd, tbl[n].wl, tbl[n].is, tbl[n].ia);
            tick();
            check($sformatf("tbl%0d.status", n), 32'(bus.mem_status), 32'(tbl[n].st));
            check($sformatf("tbl%0d.d_data", n), bus.d_mem_data, tbl[n].d);
            check($sformatf("tbl%0d.i_data", n), bus.i_mem_data, tbl[n].i);
        end
        d_exp = tbl[tbl.size() - 1].d;
        i_exp = tbl[tbl.size() - 1].i;

        // Fill the regions random traffic uses so the model is fully known.
        for (int b = 0; b < 32'h800; b += 32) write_seq(17'(b), 8, 8);
        for (int b = 32'h1FF00; b < MEMSZ; b += 32) write_seq(17'(b), 8, 8);

        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 4);
            a    = rand_addr();
            case (kind)
                0: read_one(a);
                1: burst_seq(a, $urandom_range(1, 9));
                2: begin
                    lenf = $urandom_range(0, 15);
                    write_seq(a, lenf, $urandom_range(1, clamp_l(lenf) + 1));
                end
                3: inst_read(a, 17'h0, 1'b0);
                default: inst_read(rand_addr(), a, 1'b1);
            endcase
        end

        // Reset three beats into a burst, holding a write request through reset.
        a = 17'($urandom_range(0, 32'h700));
        for (int e = 0; e < 3; e++) begin
            drive(BR, (e == 0) ? a : 17'h0, 32'h0, 4'd0, NOP, 17'h0);
            tick();
            d_exp = ref_rd(a + 17'(4 * e));
            check_bus("rst_burst", S_DATA);
        end
        #2;
        rst_n = 1'b0;
        #1;
        d_exp = 32'h0;
        i_exp = 32'h0;
        check_bus("rst_async", S_REST);
        drive(WR, a, 32'hFFFFFFFF, 4'd8, RD, a);
        tick();
        check_bus("rst_held", S_REST);
        @(negedge clk);
        drive(NOP, 17'h0, 32'h0, 4'd0, NOP, 17'h0);
        rst_n = 1'b1;
        tick();
        check_bus("rst_release", S_REST);
        read_one(a);
        read_one(a + 17'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
